frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
- Frame-level controller around one streaming filter stage, such as the non-maximum suppression stage of the Hough pipeline.
- Admits exactly one frame of WIDTH*HEIGHT pixels from the source FIFO into the filter's input FIFO.
- Forwards exactly WIDTH*HEIGHT result pixels from the filter's output FIFO downstream.
- Pulses frame_done when the frame completes. Only then is the next frame admitted, so frames never overlap inside the filter.

Parameters:
- WIDTH, 720, image width in pixels
- HEIGHT, 540, image height in pixels
- TIMEOUT_CYCLES, 65535, stall watchdog limit (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request one frame; sampled only in IDLE
- busy  out  1  high in FEED, DRAIN and DONE
- frame_done  out  1  one-cycle pulse in DONE
- frame_count  out  16  completed frames, wraps at 65535->0
- src_rd_en  out  1  source FIFO read
- src_empty  in  1  source FIFO empty
- src_dout  in  8  source pixel (first-word-fall-through)
- flt_wr_en  out  1  filter input FIFO write
- flt_full  in  1  filter input FIFO full
- flt_din  out  8  pixel to filter
- res_rd_en  out  1  filter output FIFO read
- res_empty  in  1  filter output FIFO empty
- res_dout  in  8  filtered pixel (first-word-fall-through)
- out_wr_en  out  1  downstream FIFO write
- out_full  in  1  downstream FIFO full
- out_din  out  8  pixel downstream

Behaviour:
- Timing: one clock, synchronous active-high reset.
- Reset values: state IDLE; in_cnt, out_cnt and frame_count = 0. All outputs are 0: busy, frame_done, all enables, flt_din and out_din.
- Counter width: PIXEL_COUNT = WIDTH*HEIGHT. in_cnt and out_cnt are $clog2(PIXEL_COUNT+1) bits.
- Input transfer is combinational, zero latency:
  - feed_ok = (state==FEED) && !src_empty && !flt_full && in_cnt<PIXEL_COUNT
  - src_rd_en = flt_wr_en = feed_ok; flt_din = src_dout when feed_ok, else 0
  - in_cnt increments on each feed_ok.
- Output transfer is combinational:
  - drain_ok = (state==FEED||state==DRAIN) && !res_empty && !out_full && out_cnt<PIXEL_COUNT
  - res_rd_en = out_wr_en = drain_ok; out_din = res_dout when drain_ok, else 0
  - out_cnt increments on each drain_ok.
- IDLE:
  - start=1 -> FEED, with in_cnt and out_cnt cleared.
  - start=0 -> stay.
- FEED:
  - Moves to DRAIN on the cycle in_cnt reaches PIXEL_COUNT.
  - Feeding and draining run concurrently in this state.
- DRAIN:
  - No further source reads.
  - -> DONE on the cycle out_cnt reaches PIXEL_COUNT.
- DONE (one cycle):
  - frame_done=1 and frame_count increments.
  - -> FEED if start=1 (back-to-back frames, counters cleared), else -> IDLE.
- Boundary conditions:
  - start in FEED or DRAIN is ignored and not queued.
  - Source pixels beyond PIXEL_COUNT stay in the source FIFO.
  - Result pixels beyond PIXEL_COUNT are not read.
  - A full downstream FIFO stalls out_cnt only; feeding continues until flt_full.
  - A last input and a last output landing in the same FEED cycle go to DRAIN first, then to DONE the next cycle. DONE is never skipped.
  - Reset mid-frame returns to IDLE and clears the counters. FIFO contents are not flushed; the system resets the FIFOs together with this block.

Optional Feature:
- Macro: FRAME_SEQ_TIMEOUT_EN.
- When defined:
  - Adds output port timeout (1 bit) and a 16-bit stall counter.
  - The stall counter increments each cycle in FEED or DRAIN with neither feed_ok nor drain_ok, and clears on any transfer.
  - When the counter reaches TIMEOUT_CYCLES: timeout is a 1-cycle pulse, state -> IDLE, counters clear, frame_count is unchanged, no frame_done.
- When undefined: no port, no counter, and the block waits indefinitely.

Decomposition:
- Shared package (globals): WIDTH, HEIGHT, PIXEL_COUNT and the seq_state_t enum {IDLE, FEED, DRAIN, DONE}.
- Sub-module pixel_counter: saturating up-counter with clear, increment enable and an at_limit flag. It is instantiated twice, for in_cnt and out_cnt.

Test Plan (WIDTH=4, HEIGHT=3, PIXEL_COUNT=12):
- Single frame: 20 pixels queued in the source, start pulse, filter model echoing input -> exactly 12 flt_wr_en and 12 out_wr_en; frame_done pulses once; frame_count=1; 8 pixels remain in the source.
- Backpressure: out_full held 1 for 30 cycles mid-frame -> out_cnt frozen and no out_wr_en during the hold; feeding completes the remaining input; frame_done only after the 12th output.
- Back-to-back frames: start held high across 2 frames -> DONE->FEED directly; frame_count=2; no IDLE cycle between frames.
- start ignored: start pulsed during DRAIN -> no effect; returns to IDLE after DONE.
- Reset mid-frame: reset after 5 inputs -> next cycle state=IDLE, all enables 0, in_cnt=0, frame_count unchanged.
- FRAME_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=10: source empties after 6 pixels -> timeout pulses on stall cycle 10, state=IDLE, no frame_done.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: default frame geometry and FSM states.
package frame_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 720;
    localparam int unsigned DEFAULT_HEIGHT      = 540;
    localparam int unsigned DEFAULT_PIXEL_COUNT = DEFAULT_WIDTH * DEFAULT_HEIGHT;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } seq_state_t;

    // Bits needed to hold 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_sequencer_pixel_counter.sv
// Saturating pixel counter: synchronous clear, increment enable, flag at the limit.
module pixel_counter
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_PIXEL_COUNT,
    parameter int unsigned CW    = count_width(LIMIT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    assign at_limit = (count == CW'(LIMIT));

    // Count accepted pixels; holds once the frame size is reached.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller around one streaming filter stage. Admits exactly one frame of
// WIDTH*HEIGHT pixels into the filter and forwards exactly as many results downstream.
// Optional stall watchdog: define FRAME_SEQ_TIMEOUT_EN to add the timeout port.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT
`ifdef FRAME_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        src_rd_en,
    input  logic        src_empty,
    input  logic [7:0]  src_dout,
    output logic        flt_wr_en,
    input  logic        flt_full,
    output logic [7:0]  flt_din,
    output logic        res_rd_en,
    input  logic        res_empty,
    input  logic [7:0]  res_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din
`ifdef FRAME_SEQ_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int unsigned PIXEL_COUNT = WIDTH * HEIGHT;
    localparam int unsigned CW          = count_width(PIXEL_COUNT);

    seq_state_t    state, state_next;
    logic [CW-1:0] in_cnt, out_cnt;
    logic          in_at_limit, out_at_limit;
    logic          feed_ok, drain_ok;
    logic          in_hit, out_hit;
    logic          cnt_clear;

    assign feed_ok  = (state == StFeed) && !src_empty && !flt_full && !in_at_limit;
    assign drain_ok = ((state == StFeed) || (state == StDrain)) && !res_empty && !out_full
                      && !out_at_limit;

    // Transfer that brings a counter to the frame size in this cycle.
    assign in_hit  = feed_ok && (in_cnt == CW'(PIXEL_COUNT - 1));
    assign out_hit = drain_ok && (out_cnt == CW'(PIXEL_COUNT - 1));

    pixel_counter #(
        .LIMIT (PIXEL_COUNT),
        .CW    (CW)
    ) u_in_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (feed_ok),
        .count    (in_cnt),
        .at_limit (in_at_limit)
    );

    pixel_counter #(
        .LIMIT (PIXEL_COUNT),
        .CW    (CW)
    ) u_out_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (drain_ok),
        .count    (out_cnt),
        .at_limit (out_at_limit)
    );

`ifdef FRAME_SEQ_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        stalled;
    logic        timeout_hit;

    assign stalled     = ((state == StFeed) || (state == StDrain)) && !feed_ok && !drain_ok;
    assign timeout_hit = stalled && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Consecutive stalled cycles; any transfer or leaving the active states restarts it.
    always_ff @(posedge clock) begin
        if (reset || !stalled || timeout_hit) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next state; counters are cleared whenever a new frame is entered.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        unique case (state)
            StIdle: begin
                if (start) begin
                    state_next = StFeed;
                    cnt_clear  = 1'b1;
                end
            end
            StFeed: begin
                if (in_hit) state_next = StDrain;
            end
            StDrain: begin
                // out_at_limit covers results that finished during FEED.
                if (out_at_limit || out_hit) state_next = StDone;
            end
            StDone: begin
                if (start) begin
                    state_next = StFeed;
                    cnt_clear  = 1'b1;
                end else begin
                    state_next = StIdle;
                end
            end
            default: state_next = StIdle;
        endcase
`ifdef FRAME_SEQ_TIMEOUT_EN
        if (timeout_hit) begin
            state_next = StIdle;
            cnt_clear  = 1'b1;
        end
`endif
    end

    // Outputs: FIFO handshakes are combinational so a pixel moves in the cycle it is offered.
    always_comb begin
        busy       = (state != StIdle);
        frame_done = (state == StDone);
        src_rd_en  = feed_ok;
        flt_wr_en  = feed_ok;
        flt_din    = feed_ok ? src_dout : 8'd0;
        res_rd_en  = drain_ok;
        out_wr_en  = drain_ok;
        out_din    = drain_ok ? res_dout : 8'd0;
`ifdef FRAME_SEQ_TIMEOUT_EN
        timeout    = timeout_hit;
`endif
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state == StDone) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule
